// File: rtl/ldl_sfifo_v2.sv
// Single-clock synchronous FIFO with arbitrary depth, programmable almost-full/
// almost-empty thresholds, overflow/underflow pulses, flush, and show-ahead or registered read.
module ldl_sfifo_v2 #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AHEAD = 1,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [DW-1:0] din,
  input  logic          re,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  input  logic [CW-1:0] afull_th,
  input  logic [CW-1:0] aempty_th,
  output logic          afull,
  output logic          aempty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;
  logic [CW-1:0] count_nxt;

  // Acceptance uses the flags registered before this edge.
  assign wr_ok     = we & ~full;
  assign rd_ok     = re & ~empty;
  assign count_nxt = count + CW'(wr_ok) - CW'(rd_ok);

  // Pointers wrap explicitly so a non-power-of-two depth never aliases.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= ptr_inc(wptr);
      if (rd_ok) rptr <= ptr_inc(rptr);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      afull     <= (count_nxt >= afull_th);
      aempty    <= (count_nxt <= aempty_th);
      overflow  <= we & full;
      underflow <= re & empty;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst && !clr) mem[wptr] <= din;
  end

  generate
    if (AHEAD != 0) begin : g_ahead
      assign dout = empty ? '0 : mem[rptr];
    end else begin : g_reg
      // Flush deliberately leaves the last delivered word on the output.
      always_ff @(posedge clk) begin
        if (rst)               dout <= '0;
        else if (rd_ok && !clr) dout <= mem[rptr];
      end
    end
  endgenerate

endmodule
